// File: rtl/ahb_vga_wbuf.sv
// ahb_vga_wbuf: AHB-Lite write buffer in front of the VGA peripheral.
// Upstream byte writes are queued without wait states and replayed in
// order as AHB write transfers to the VGA slave. The upstream bus stalls
// only when the queue is full.
// Optional build macro VGA_WBUF_STATUS_EN: HRDATA returns a fill/status
// word. Without it, HRDATA is always zero.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | queue empty or just drained, no transfer driven to the VGA slave
// ADDR  | NONSEQ write address phase for the head entry
// DATA  | data phase for the head entry; pops when the VGA slave is ready
module ahb_vga_wbuf #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h5000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        M_HSEL,
    output logic [31:0] M_HADDR,
    output logic        M_HWRITE,
    output logic [1:0]  M_HTRANS,
    output logic [31:0] M_HWDATA,
    output logic        M_HREADY,
    input  logic        M_HREADYOUT
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    state_t         state;
    logic [23:0]    addr_q;
    logic           sel_q;
    logic           write_q;
    logic           trans_q;
    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [31:0]    head;
    logic [31:0]    head_next;
    logic           unused_bits;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign HREADYOUT = ~full;
    assign M_HREADY  = M_HREADYOUT;

    // A write data phase completes only when the bus is ready and there is room.
    assign push      = sel_q & write_q & trans_q & HREADY & ~full;
    assign pop       = (state == ST_DATA) & M_HREADYOUT;

    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + PTR_ONE];

    assign unused_bits = ^{HADDR[31:24], HTRANS[0], HWDATA[31:8]};

`ifdef VGA_WBUF_STATUS_EN
    logic [5:0] count_ext;
    assign count_ext = 6'(count);
    assign HRDATA    = HRESETn ? {22'h0, full, empty, 2'b00, count_ext} : 32'h0;
`else
    assign HRDATA    = 32'h0;
`endif

    // Capture the upstream address phase whenever the bus advances.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q  <= '0;
            sel_q   <= 1'b0;
            write_q <= 1'b0;
            trans_q <= 1'b0;
        end else if (HREADY) begin
            addr_q  <= HADDR[23:0];
            sel_q   <= HSEL;
            write_q <= HWRITE;
            trans_q <= HTRANS[1];
        end
    end

    // Queue storage; contents are don't-care while the count says empty.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr] <= {addr_q, HWDATA[7:0]};
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Replay FSM with registered master-side outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            M_HSEL   <= 1'b0;
            M_HWRITE <= 1'b0;
            M_HTRANS <= 2'b00;
            M_HADDR  <= {BASE_ADDR[31:24], 24'h0};
            M_HWDATA <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state    <= ST_ADDR;
                        M_HSEL   <= 1'b1;
                        M_HWRITE <= 1'b1;
                        M_HTRANS <= 2'b10;
                        M_HADDR  <= {BASE_ADDR[31:24], head[31:8]};
                    end
                end
                ST_ADDR: begin
                    if (M_HREADYOUT) begin
                        state    <= ST_DATA;
                        M_HSEL   <= 1'b0;
                        M_HTRANS <= 2'b00;
                        M_HWDATA <= {24'h0, head[7:0]};
                    end
                end
                ST_DATA: begin
                    if (M_HREADYOUT) begin
                        if (count > CNT_ONE) begin
                            // Another entry is already queued: go straight to its address phase.
                            state    <= ST_ADDR;
                            M_HSEL   <= 1'b1;
                            M_HWRITE <= 1'b1;
                            M_HTRANS <= 2'b10;
                            M_HADDR  <= {BASE_ADDR[31:24], head_next[31:8]};
                        end else begin
                            state    <= ST_IDLE;
                            M_HWRITE <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    M_HSEL   <= 1'b0;
                    M_HWRITE <= 1'b0;
                    M_HTRANS <= 2'b00;
                end
            endcase
        end
    end

endmodule
